dac_i2c_responder: RTL and testbench

- Simulation and bring-up model of the MCP4725-class DAC target, at the far end of the DAC I2C bus.
- Oversamples SCL/SDA on CLOCK_50, decodes 4-byte write frames (address, command, data MSB, data LSB), ACKs valid bytes by pulling SDA low, and presents the 12-bit DAC code.
- Also presents the reconstructed signed 16-bit audio sample, so benches can check the DAC path end to end.

---
 rtl/dac_i2c_responder.sv | 182 ++++++++++++++++++
 tb/tb_dac_i2c_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_i2c_responder.sv
// dac_i2c_responder: I2C target model of an MCP4725-class DAC.
// Decodes 4-byte write frames (address, command, code MSB, code LSB),
// ACKs accepted bytes, and presents the 12-bit DAC code along with the
// matching signed 16-bit audio sample.
//
// state     | meaning
// ----------+-------------------------------------------------------
// IDLE      | bus free, waiting for START
// ADDR      | shifting in the address byte
// ACK_ADDR  | acknowledging our write address
// CMD       | shifting in the command byte
// ACK_CMD   | acknowledging a write-DAC-register command
// MSB       | shifting in code[11:4]
// ACK_MSB   | acknowledging the MSB byte
// LSB       | shifting in code[3:0] (low nibble of the byte dropped)
// ACK_LSB   | acknowledging the LSB byte, code already committed
// WAIT_STOP | frame complete, extra bytes NACKed until STOP
// IGNORE    | not for us (or bad command), stay silent until STOP/START
module dac_i2c_responder #(
  parameter logic [6:0]  DEV_ADDR    = 7'h60,
  parameter logic [2:0]  CMD_EXPECT  = 3'b010,
  parameter logic [11:0] RESET_CODE  = 12'h800,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        CLOCK_50,
  input  logic        iRST_N,
  input  logic        DAC_I2C_SCLK,
  inout  wire         DAC_I2C_SDAT,
  output logic [11:0] dac_value,
  output logic [15:0] audio_out_signed,
  output logic        dac_valid,
  output logic        frame_err,
  output logic [15:0] frame_count,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_ADDR, CMD, ACK_CMD, MSB, ACK_MSB, LSB, ACK_LSB,
    WAIT_STOP, IGNORE
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl;
  logic                   sda;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start_det;
  logic                   stop_det;
  logic [2:0]             bit_cnt;
  logic [6:0]             shift_reg;
  logic [7:0]             byte_next;
  logic [7:0]             code_hi;
  logic                   sda_oe;

  // Open-drain output: only ever pull low or release.
  assign DAC_I2C_SDAT = sda_oe ? 1'b0 : 1'bz;

  assign scl       = scl_sync[SYNC_STAGES-1];
  assign sda       = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl & ~scl_d;
  assign scl_fall  = ~scl & scl_d;
  // SCL must be stable high across the SDA edge to qualify as START/STOP.
  assign start_det = ~sda & sda_d & scl & scl_d;
  assign stop_det  = sda & ~sda_d & scl & scl_d;
  assign byte_next = {shift_reg, sda};

  // Synchronise the bus lines; reset to the idle-high level so release of
  // reset never looks like a bus edge.
  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], DAC_I2C_SCLK};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], DAC_I2C_SDAT};
      scl_d    <= scl;
      sda_d    <= sda;
    end
  end

  // Frame decoder, ACK driver and output registers.
  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      state            <= IDLE;
      bit_cnt          <= 3'd0;
      shift_reg        <= 7'd0;
      code_hi          <= RESET_CODE[11:4];
      sda_oe           <= 1'b0;
      dac_value        <= RESET_CODE;
      audio_out_signed <= 16'h0000;
      dac_valid        <= 1'b0;
      frame_err        <= 1'b0;
      frame_count      <= 16'd0;
      busy             <= 1'b0;
    end else begin
      dac_valid <= 1'b0;
      frame_err <= 1'b0;
      if (start_det || stop_det) begin
        // An addressed frame cut short before its LSB was sampled.
        if (state inside {CMD, ACK_CMD, MSB, ACK_MSB, LSB})
          frame_err <= 1'b1;
        sda_oe  <= 1'b0;
        bit_cnt <= 3'd0;
        if (start_det) begin
          state <= ADDR;
          busy  <= 1'b1;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end else begin
        case (state)
          ADDR, CMD, MSB, LSB: begin
            if (scl_rise) begin
              shift_reg <= byte_next[6:0];
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                case (state)
                  ADDR: begin
                    if (byte_next[7:1] == DEV_ADDR && !byte_next[0]) begin
                      state <= ACK_ADDR;
                    end else begin
                      state <= IGNORE;
                      busy  <= 1'b0;
                    end
                  end
                  CMD: begin
                    if (byte_next[7:5] == CMD_EXPECT) begin
                      state <= ACK_CMD;
                    end else begin
                      state <= IGNORE;
                      busy  <= 1'b0;
                    end
                  end
                  MSB: begin
                    code_hi <= byte_next;
                    state   <= ACK_MSB;
                  end
                  default: begin
                    dac_value        <= {code_hi, byte_next[7:4]};
                    audio_out_signed <= {~code_hi[7], code_hi[6:0],
                                         byte_next[7:4], 4'b0000};
                    dac_valid        <= 1'b1;
                    frame_count      <= frame_count + 16'd1;
                    state            <= ACK_LSB;
                  end
                endcase
              end
            end
          end
          ACK_ADDR, ACK_CMD, ACK_MSB, ACK_LSB: begin
            // First SCL fall: pull SDA low; second fall: release and move on.
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                case (state)
                  ACK_ADDR: state <= CMD;
                  ACK_CMD:  state <= MSB;
                  ACK_MSB:  state <= LSB;
                  default:  state <= WAIT_STOP;
                endcase
              end
            end
          end
          default: begin
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dac_i2c_responder.sv
// tb_dac_i2c_responder: directed I2C write frames against the DAC responder.
module tb_dac_i2c_responder;

  localparam int Q = 8;

  logic        CLOCK_50;
  logic        iRST_N;
  logic        scl_drv;
  logic        sda_low;
  wire         sda_line;
  logic [11:0] dac_value;
  logic [15:0] audio_out_signed;
  logic        dac_valid;
  logic        frame_err;
  logic [15:0] frame_count;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int both_cnt  = 0;
  int drive_cnt = 0;
  int cyc       = 0;
  int last_rise = 0;
  int lat       = 0;
  logic acked;

  assign sda_line = sda_low ? 1'b0 : 1'bz;
  pullup (sda_line);

  dac_i2c_responder dut (
    .CLOCK_50         (CLOCK_50),
    .iRST_N           (iRST_N),
    .DAC_I2C_SCLK     (scl_drv),
    .DAC_I2C_SDAT     (sda_line),
    .dac_value        (dac_value),
    .audio_out_signed (audio_out_signed),
    .dac_valid        (dac_valid),
    .frame_err        (frame_err),
    .frame_count      (frame_count),
    .busy             (busy)
  );

  // 50 MHz clock.
  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  // Cycle counter for latency measurement.
  always @(posedge CLOCK_50) cyc++;

  // Remember the cycle of the most recent SCL rise at the pin.
  always @(posedge scl_drv) last_rise = cyc;

  // Count output pulses away from the active edge.
  always @(negedge CLOCK_50) begin
    if (dac_valid) begin
      valid_cnt++;
      lat = cyc - last_rise;
    end
    if (frame_err) err_cnt++;
    if (dac_valid && frame_err) both_cnt++;
  end

  // Count cycles where the DUT pulls SDA while the bench has released it.
  always begin
    @(posedge CLOCK_50);
    #2;
    if (sda_line === 1'b0 && !sda_low) drive_cnt++;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic i2c_start();
    sda_low = 1'b0; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    sda_low = 1'b1; wait_clk(Q);
    scl_drv = 1'b0; wait_clk(2);
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    sda_low = 1'b0; wait_clk(Q);
  endtask

  task automatic write_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_low = ~b[i]; wait_clk(Q);
      scl_drv = 1'b1;  wait_clk(Q);
      scl_drv = 1'b0;  wait_clk(2);
    end
  endtask

  task automatic ack_slot(output logic ack);
    sda_low = 1'b0; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q / 2);
    ack = (sda_line === 1'b0);
    wait_clk(Q / 2);
    scl_drv = 1'b0; wait_clk(2);
  endtask

  task automatic send_byte(input string tag, input logic [7:0] b, input logic exp_ack);
    logic a;
    write_bits(b);
    ack_slot(a);
    check(tag, {31'd0, a}, {31'd0, exp_ack});
  endtask

  task automatic full_frame(input logic [7:0] msb, input logic [7:0] lsb);
    i2c_start();
    send_byte("ff_addr", 8'hC0, 1'b1);
    send_byte("ff_cmd",  8'h40, 1'b1);
    send_byte("ff_msb",  msb,   1'b1);
    send_byte("ff_lsb",  lsb,   1'b1);
    i2c_stop();
  endtask

  initial begin
    int v0, e0;
    iRST_N  = 1'b0;
    scl_drv = 1'b1;
    sda_low = 1'b0;
    wait_clk(5);
    check("rst_dac",   {20'd0, dac_value}, 32'h800);
    check("rst_audio", {16'd0, audio_out_signed}, 32'h0000);
    check("rst_valid", {31'd0, dac_valid}, 32'd0);
    check("rst_err",   {31'd0, frame_err}, 32'd0);
    check("rst_count", {16'd0, frame_count}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_sda",   {31'd0, sda_line}, 32'd1);
    iRST_N = 1'b1;
    wait_clk(5);

    // Foreign address: never driven, no error, busy drops after 8th bit.
    drive_cnt = 0;
    i2c_start();
    check("c2_busy_start", {31'd0, busy}, 32'd1);
    send_byte("c2_addr_nack", 8'hC2, 1'b0);
    check("c2_busy_after", {31'd0, busy}, 32'd0);
    send_byte("c2_b1_nack", 8'h40, 1'b0);
    send_byte("c2_b2_nack", 8'hAB, 1'b0);
    send_byte("c2_b3_nack", 8'hC0, 1'b0);
    i2c_stop();
    check("c2_drive",  drive_cnt, 32'd0);
    check("c2_dac",    {20'd0, dac_value}, 32'h800);
    check("c2_count",  {16'd0, frame_count}, 32'd0);
    check("c2_err",    err_cnt, 32'd0);

    // Read address, then a wrong command in its own frame.
    i2c_start();
    send_byte("c1_nack", 8'hC1, 1'b0);
    i2c_stop();
    i2c_start();
    send_byte("cmd_addr", 8'hC0, 1'b1);
    send_byte("cmd60_nack", 8'h60, 1'b0);
    send_byte("cmd60_b2_nack", 8'hAB, 1'b0);
    i2c_stop();
    check("nack_valid", valid_cnt, 32'd0);
    check("nack_err",   err_cnt, 32'd0);
    check("nack_dac",   {20'd0, dac_value}, 32'h800);

    // Main frame C0 40 AB C0.
    i2c_start();
    check("main_busy", {31'd0, busy}, 32'd1);
    send_byte("main_ack_addr", 8'hC0, 1'b1);
    send_byte("main_ack_cmd",  8'h40, 1'b1);
    send_byte("main_ack_msb",  8'hAB, 1'b1);
    send_byte("main_ack_lsb",  8'hC0, 1'b1);
    send_byte("main_extra_nack", 8'h55, 1'b0);
    i2c_stop();
    check("main_dac",   {20'd0, dac_value}, 32'hABC);
    check("main_audio", {16'd0, audio_out_signed}, 32'h2BC0);
    check("main_valid", valid_cnt, 32'd1);
    check("main_count", {16'd0, frame_count}, 32'd1);
    check("main_lat",   lat, 32'd3);
    check("main_busy_stop", {31'd0, busy}, 32'd0);

    // Aborted frame by STOP in LSB.
    e0 = err_cnt; v0 = valid_cnt;
    i2c_start();
    send_byte("abort_addr", 8'hC0, 1'b1);
    send_byte("abort_cmd",  8'h40, 1'b1);
    send_byte("abort_msb",  8'h12, 1'b1);
    i2c_stop();
    check("abort_err",   err_cnt - e0, 32'd1);
    check("abort_dac",   {20'd0, dac_value}, 32'hABC);
    check("abort_valid", valid_cnt - v0, 32'd0);

    // Repeated START in MSB, then a full frame.
    i2c_start();
    send_byte("rs_addr", 8'hC0, 1'b1);
    send_byte("rs_cmd",  8'h40, 1'b1);
    full_frame(8'hFF, 8'hF0);
    check("rs_err",   err_cnt - e0, 32'd2);
    check("rs_dac",   {20'd0, dac_value}, 32'hFFF);
    check("rs_audio", {16'd0, audio_out_signed}, 32'h7FF0);
    check("rs_count", {16'd0, frame_count}, 32'd2);

    // Code boundaries.
    full_frame(8'h00, 8'h00);
    check("code000_audio", {16'd0, audio_out_signed}, 32'h8000);
    full_frame(8'h80, 8'h00);
    check("code800_audio", {16'd0, audio_out_signed}, 32'h0000);
    check("code800_dac",   {20'd0, dac_value}, 32'h800);

    // Frame counter wrap.
    @(negedge CLOCK_50);
    force dut.frame_count = 16'hFFFF;
    @(negedge CLOCK_50);
    release dut.frame_count;
    wait_clk(2);
    check("wrap_preset", {16'd0, frame_count}, 32'hFFFF);
    v0 = valid_cnt;
    full_frame(8'h12, 8'h30);
    check("wrap_count", {16'd0, frame_count}, 32'd0);
    check("wrap_valid", valid_cnt - v0, 32'd1);
    check("never_both", both_cnt, 32'd0);

    // Reset while the MSB ACK is being driven.
    i2c_start();
    send_byte("mid_addr", 8'hC0, 1'b1);
    send_byte("mid_cmd",  8'h40, 1'b1);
    write_bits(8'h5A);
    sda_low = 1'b0; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q / 2);
    check("mid_ack_driven", {31'd0, sda_line}, 32'd0);
    iRST_N = 1'b0;
    #1;
    check("mid_sda_released", {31'd0, sda_line}, 32'd1);
    wait_clk(2);
    check("mid_dac",   {20'd0, dac_value}, 32'h800);
    check("mid_audio", {16'd0, audio_out_signed}, 32'h0000);
    check("mid_count", {16'd0, frame_count}, 32'd0);
    check("mid_busy",  {31'd0, busy}, 32'd0);
    wait_clk(3);
    iRST_N = 1'b1;
    wait_clk(Q);
    full_frame(8'h34, 8'h50);
    check("post_dac",   {20'd0, dac_value}, 32'h345);
    check("post_audio", {16'd0, audio_out_signed}, 32'hB450);
    check("post_count", {16'd0, frame_count}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
